// File: rtl/traffic_pkg.sv
// Shared phase/owner encodings and the round-robin successor search for the
// three-approach intersection arbiter.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        OWN_R1 = 2'd0,
        OWN_R2 = 2'd1,
        OWN_F  = 2'd2
    } owner_t;

    // First waiting approach after cur, in the order R1 -> R2 -> F -> R1.
    function automatic owner_t rrNext(input owner_t cur, input logic [2:0] waiting);
        owner_t     result;
        logic [1:0] idx;
        logic       found;
        result = cur;
        found  = 1'b0;
        idx    = cur;
        for (int step = 0; step < 3; step++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (!found && waiting[idx]) begin
                result = owner_t'(idx);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/traffic_phase_arbiter_timer.sv
// Phase timer: counts up from zero after each clear and holds at the limit;
// tc flags that the limit has been reached.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count < limit)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Round-robin right-of-way scheduler for R1/R2/F with bounded green, fixed
// yellow and all-red clearance, driving registered lamp outputs.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic       R1G,
    output logic       R1Y,
    output logic       R1R,
    output logic       R2G,
    output logic       R2Y,
    output logic       R2R,
    output logic       FG,
    output logic       FY,
    output logic       FR,
    output logic [1:0] owner,
    output logic [1:0] phase
);

    localparam logic [CNT_W-1:0] GMIN_LIM   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LIM   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LIM = CNT_W'(ALLRED_T - 1);
    localparam logic [8:0]       LAMPS_RST  = 9'b100_100_001;

    phase_t           phaseQ, phaseD;
    owner_t           ownerQ, ownerD, nextOwnerQ, nextOwnerD;
    logic [2:0]       pendQ, pendD, ownerMask, other;
    logic [8:0]       lampQ, lampD;
    logic [CNT_W-1:0] timerLimit, timerCount;
    logic             timerTc, ownerReq;

    always_comb begin
        unique case (phaseQ)
            YELLOW:  timerLimit = YELLOW_LIM;
            ALLRED:  timerLimit = ALLRED_LIM;
            default: timerLimit = GMAX_LIM;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (phaseD != phaseQ),
        .enable (1'b1),
        .limit  (timerLimit),
        .count  (timerCount),
        .tc     (timerTc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phaseQ     <= GREEN;
            ownerQ     <= OWN_R1;
            nextOwnerQ <= OWN_R1;
            pendQ      <= '0;
            lampQ      <= LAMPS_RST;
        end else begin
            phaseQ     <= phaseD;
            ownerQ     <= ownerD;
            nextOwnerQ <= nextOwnerD;
            pendQ      <= pendD;
            lampQ      <= lampD;
        end
    end

    assign ownerMask = 3'b001 << ownerQ;
    assign other     = pendQ & ~ownerMask;
    assign ownerReq  = |(req & ownerMask);

    // In GREEN the saturated timer (tc) doubles as the GREEN_MAX bound.
    always_comb begin
        phaseD     = phaseQ;
        ownerD     = ownerQ;
        nextOwnerD = nextOwnerQ;
        pendD      = pendQ | (req & ((phaseQ == GREEN) ? ~ownerMask : 3'b111));
        unique case (phaseQ)
            GREEN: begin
                if ((other != 3'b000) && (timerCount >= GMIN_LIM) && (!ownerReq || timerTc)) begin
                    phaseD     = YELLOW;
                    nextOwnerD = rrNext(ownerQ, other);
                end
            end
            YELLOW: begin
                if (timerTc) phaseD = ALLRED;
            end
            ALLRED: begin
                if (timerTc) begin
                    phaseD = GREEN;
                    ownerD = nextOwnerQ;
                    pendD  = pendD & ~(3'b001 << nextOwnerQ);
                end
            end
            default: phaseD = GREEN;
        endcase
    end

    // Lamps are decoded from the upcoming state so the registered copy lines up with phase/owner.
    always_comb begin
        lampD = '0;
        for (int a = 0; a < 3; a++) begin
            if (ownerD == owner_t'(a)) begin
                unique case (phaseD)
                    GREEN:   lampD[3*a]     = 1'b1;
                    YELLOW:  lampD[3*a + 1] = 1'b1;
                    default: lampD[3*a + 2] = 1'b1;
                endcase
            end else begin
                lampD[3*a + 2] = 1'b1;
            end
        end
    end

    assign {FR, FY, FG, R2R, R2Y, R2G, R1R, R1Y, R1G} = lampQ;
    assign owner = ownerQ;
    assign phase = phaseQ;

endmodule
